// File: rtl/encoder.sv
// encoder: transmit-side USB4 line encoder.
// Packs lockstep lane 0/1 byte streams into 128b/132b (Gen3) or 64b/66b (Gen2)
// blocks with a shared sync header, or passes bytes straight through (Gen4).
module encoder #(
    parameter logic [1:0] GEN4      = 2'd0,
    parameter logic [1:0] GEN3      = 2'd1,
    parameter logic [1:0] GEN2      = 2'd2,
    parameter logic [3:0] HDR3_DATA = 4'b0101,
    parameter logic [3:0] HDR3_OS   = 4'b1010,
    parameter logic [1:0] HDR2_DATA = 2'b01,
    parameter logic [1:0] HDR2_OS   = 2'b10
) (
    input  logic         enc_clk,
    input  logic         rst,
    input  logic         enable_enc,
    input  logic [1:0]   gen_speed,
    input  logic         data_os,
    input  logic [7:0]   lane_0_tx,
    input  logic [7:0]   lane_1_tx,
    output logic [131:0] lane_0_tx_enc,
    output logic [131:0] lane_1_tx_enc,
    output logic         enc_valid
);

    logic [1:0]   gen_q;
    logic [3:0]   cnt;
    logic [3:0]   cnt_eff;
    logic [3:0]   cnt_max;
    logic         mode_ok;
    logic         accept;
    logic         last;
    logic         type_q;
    logic         type_eff;
    logic [7:0]   base;
    logic [131:0] pay0_q;
    logic [131:0] pay1_q;
    logic [131:0] pay0_nx;
    logic [131:0] pay1_nx;
    logic [131:0] blk0;
    logic [131:0] blk1;

    // Mode decode: block length, byte acceptance and effective byte position.
    // A gen_speed change restarts the block so the current byte becomes byte 0.
    always_comb begin
        mode_ok  = (gen_speed == GEN4) || (gen_speed == GEN3) || (gen_speed == GEN2);
        cnt_max  = '0;
        if (gen_speed == GEN3)
            cnt_max = 4'd15;
        else if (gen_speed == GEN2)
            cnt_max = 4'd7;
        accept   = enable_enc && mode_ok;
        cnt_eff  = (gen_speed != gen_q) ? '0 : cnt;
        last     = accept && (cnt_eff == cnt_max);
        type_eff = (cnt_eff == '0) ? data_os : type_q;
    end

    // Insert the current lane bytes into the payload at their header-offset slot.
    always_comb begin
        pay0_nx = pay0_q;
        pay1_nx = pay1_q;
        base    = {1'b0, cnt_eff, 3'b000} + ((gen_speed == GEN3) ? 8'd4 : 8'd2);
        if (gen_speed == GEN3 || gen_speed == GEN2) begin
            pay0_nx[base +: 8] = lane_0_tx;
            pay1_nx[base +: 8] = lane_1_tx;
        end
    end

    // Assemble the finished block for the active mode.
    always_comb begin
        blk0 = {124'b0, lane_0_tx};
        blk1 = {124'b0, lane_1_tx};
        if (gen_speed == GEN3) begin
            blk0 = {pay0_nx[131:4], type_eff ? HDR3_DATA : HDR3_OS};
            blk1 = {pay1_nx[131:4], type_eff ? HDR3_DATA : HDR3_OS};
        end else if (gen_speed == GEN2) begin
            blk0 = {66'b0, pay0_nx[65:2], type_eff ? HDR2_DATA : HDR2_OS};
            blk1 = {66'b0, pay1_nx[65:2], type_eff ? HDR2_DATA : HDR2_OS};
        end
    end

    // Counter, payload and output registers; a stall or mode change drops the partial block.
    always_ff @(posedge enc_clk) begin
        if (rst) begin
            gen_q         <= GEN4;
            cnt           <= '0;
            type_q        <= 1'b0;
            pay0_q        <= '0;
            pay1_q        <= '0;
            lane_0_tx_enc <= '0;
            lane_1_tx_enc <= '0;
            enc_valid     <= 1'b0;
        end else begin
            gen_q     <= gen_speed;
            enc_valid <= last;
            if (accept) begin
                pay0_q <= pay0_nx;
                pay1_q <= pay1_nx;
                if (cnt_eff == '0)
                    type_q <= data_os;
                cnt <= last ? '0 : cnt_eff + 4'd1;
            end else begin
                cnt <= '0;
            end
            if (last) begin
                lane_0_tx_enc <= blk0;
                lane_1_tx_enc <= blk1;
            end
        end
    end

endmodule

// File: tb/tb_encoder.sv
// tb_encoder: directed scenarios plus random traffic checked against a
// byte-queue reference model of the encoder.
module tb_encoder;

    logic         enc_clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable_enc = 1'b0;
    logic [1:0]   gen_speed = 2'd1;
    logic         data_os = 1'b0;
    logic [7:0]   lane_0_tx = '0;
    logic [7:0]   lane_1_tx = '0;
    logic [131:0] lane_0_tx_enc;
    logic [131:0] lane_1_tx_enc;
    logic         enc_valid;

    encoder dut (
        .enc_clk       (enc_clk),
        .rst           (rst),
        .enable_enc    (enable_enc),
        .gen_speed     (gen_speed),
        .data_os       (data_os),
        .lane_0_tx     (lane_0_tx),
        .lane_1_tx     (lane_1_tx),
        .lane_0_tx_enc (lane_0_tx_enc),
        .lane_1_tx_enc (lane_1_tx_enc),
        .enc_valid     (enc_valid)
    );

    always #5 enc_clk = ~enc_clk;

    int unsigned  n_assert = 0;
    int unsigned  n_fail   = 0;

    // Reference model state: bytes collected so far in the current block.
    logic [7:0]   q0[$];
    logic [7:0]   q1[$];
    logic         blk_type = 1'b0;
    int           prev_gen = -1;
    logic [131:0] exp0 = '0;
    logic [131:0] exp1 = '0;
    logic         exp_v = 1'b0;

    function automatic logic [131:0] build(input int g, input logic t, input logic [7:0] q[$]);
        logic [131:0] r;
        r = '0;
        if (g == 0) begin
            r[7:0] = q[0];
        end else if (g == 1) begin
            for (int k = 0; k < 16; k++) r[4 + 8*k +: 8] = q[k];
            r[3:0] = t ? 4'b0101 : 4'b1010;
        end else begin
            for (int k = 0; k < 8; k++) r[2 + 8*k +: 8] = q[k];
            r[1:0] = t ? 2'b01 : 2'b10;
        end
        return r;
    endfunction

    task automatic model(input logic r, input logic e, input logic [1:0] g,
                         input logic d, input logic [7:0] b0, input logic [7:0] b1);
        int n;
        exp_v = 1'b0;
        if (r) begin
            q0.delete(); q1.delete();
            exp0 = '0; exp1 = '0;
        end else begin
            if (int'(g) != prev_gen) begin q0.delete(); q1.delete(); end
            if (!e || g == 2'd3) begin
                q0.delete(); q1.delete();
            end else begin
                if (q0.size() == 0) blk_type = d;
                q0.push_back(b0); q1.push_back(b1);
                n = (g == 2'd1) ? 16 : (g == 2'd2) ? 8 : 1;
                if (q0.size() == n) begin
                    exp0 = build(int'(g), blk_type, q0);
                    exp1 = build(int'(g), blk_type, q1);
                    exp_v = 1'b1;
                    q0.delete(); q1.delete();
                end
            end
        end
        prev_gen = int'(g);
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] g,
                        input logic d, input logic [7:0] b0, input logic [7:0] b1);
        rst = r; enable_enc = e; gen_speed = g; data_os = d;
        lane_0_tx = b0; lane_1_tx = b1;
        @(posedge enc_clk);
        model(r, e, g, d, b0, b1);
        #1;
        n_assert++;
        assert (enc_valid === exp_v) else begin
            n_fail++;
            $error("FAIL enc_valid @%0t: observed %0b expected %0b", $time, enc_valid, exp_v);
        end
        n_assert++;
        assert (lane_0_tx_enc === exp0) else begin
            n_fail++;
            $error("FAIL lane0 @%0t: observed %h expected %h", $time, lane_0_tx_enc, exp0);
        end
        n_assert++;
        assert (lane_1_tx_enc === exp1) else begin
            n_fail++;
            $error("FAIL lane1 @%0t: observed %h expected %h", $time, lane_1_tx_enc, exp1);
        end
    endtask

    logic [1:0] rg;

    initial begin
        // Reset state, including rst winning over enable_enc.
        step(1, 0, 2'd1, 0, 8'h00, 8'h00);
        step(1, 1, 2'd1, 1, 8'h55, 8'hAA);

        // 1: Gen3 data block.
        for (int k = 0; k < 16; k++)
            step(0, 1, 2'd1, 1, 8'(k), 8'(8'hF0 + k));
        n_assert++;
        assert (lane_0_tx_enc === 132'h0F0E0D0C0B0A090807060504030201005) else begin
            n_fail++;
            $error("FAIL gen3_const: observed %h expected %h", lane_0_tx_enc,
                   132'h0F0E0D0C0B0A090807060504030201005);
        end
        step(0, 0, 2'd1, 0, 8'h00, 8'h00);

        // 2: Gen2 ordered set, data_os toggling after byte 0.
        for (int k = 0; k < 8; k++)
            step(0, 1, 2'd2, (k % 2 == 1), 8'(8'hA0 + k), 8'(8'hB0 + k));
        step(0, 0, 2'd2, 1, 8'h00, 8'h00);

        // 3: Gen4 pass-through for 5 cycles.
        for (int k = 1; k <= 5; k++)
            step(0, 1, 2'd0, 1, 8'(8'h11 * k), 8'(8'h0F + k));
        step(0, 0, 2'd0, 0, 8'h00, 8'h00);

        // 4: Gen3 stall after byte 9, then a full fresh block.
        for (int k = 0; k < 10; k++) step(0, 1, 2'd1, 1, 8'(8'h30 + k), 8'(8'h40 + k));
        step(0, 0, 2'd1, 1, 8'hEE, 8'hEE);
        for (int k = 0; k < 16; k++) step(0, 1, 2'd1, 0, 8'(8'h60 + k), 8'(8'h80 + k));

        // 5: reset at byte 6 of a Gen2 block, then a full block.
        for (int k = 0; k < 6; k++) step(0, 1, 2'd2, 1, 8'(8'hC0 + k), 8'(8'hD0 + k));
        step(1, 1, 2'd2, 1, 8'hC6, 8'hD6);
        for (int k = 0; k < 8; k++) step(0, 1, 2'd2, 1, 8'(8'h70 + k), 8'(8'h78 + k));

        // 6: three back-to-back Gen3 blocks, switch to Gen2 at byte 4 of the fourth.
        for (int k = 0; k < 52; k++) step(0, 1, 2'd1, 1, 8'($urandom), 8'($urandom));
        for (int k = 0; k < 8; k++) step(0, 1, 2'd2, 0, 8'($urandom), 8'($urandom));

        // gen_speed=3 accepts nothing.
        for (int k = 0; k < 4; k++) step(0, 1, 2'd3, 1, 8'hFF, 8'hFF);

        // Random traffic.
        rg = 2'd1;
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 59) == 0) rg = 2'($urandom_range(0, 3));
            step($urandom_range(0, 149) == 0, $urandom_range(0, 24) != 0, rg,
                 1'($urandom), 8'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
